// File: rtl/dm_arbiter_pkg.sv
// Shared constants and state type for the two-requester data-memory arbiter.
package dm_arbiter_pkg;

  localparam int DATA_WIDTH = 19;
  localparam int ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dm_arb_state_t;

endpackage

// File: rtl/dm_arbiter_rr_pick2.sv
// Two-way round-robin winner selection; purely combinational.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_idx
);

  // On a tie the requester that did not win last time is favoured.
  always_comb begin
    grant_valid = |req;
    grant_idx   = 1'b0;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Shares one single-port data memory between two requesters with a
// three-state IDLE/ACCESS/RESP handshake and round-robin arbitration.
module dm_arbiter
  import dm_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  WR_EN_DM,
  output logic                  RD_EN_DM,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  grant_id
);

  dm_arb_state_t         r_state;
  dm_arb_state_t         w_state_nxt;
  logic                  r_last;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_grant_id;
  logic                  r_wr_en;
  logic                  r_rd_en;
  logic                  r_ack0;
  logic                  r_ack1;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;

  logic                  w_grant_valid;
  logic                  w_grant_idx;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  rr_pick2 u_pick (
    .req         ({req1, req0}),
    .last        (r_last),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  assign w_sel_we    = w_grant_idx ? we1    : we0;
  assign w_sel_addr  = w_grant_idx ? addr1  : addr0;
  assign w_sel_wdata = w_grant_idx ? wdata1 : wdata0;

  // Next-state decode; requests only matter while IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_state_nxt = ACCESS;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCESS:  w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered datapath and handshake outputs, all derived from the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last     <= 1'b1;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_grant_id <= 1'b0;
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_busy     <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_busy  <= (w_state_nxt != IDLE);
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_we       <= w_sel_we;
            r_addr     <= w_sel_addr;
            r_wdata    <= w_sel_wdata;
            r_grant_id <= w_grant_idx;
            r_last     <= w_grant_idx;
            r_wr_en    <= w_sel_we;
            r_rd_en    <= ~w_sel_we;
          end
        end
        ACCESS: begin
          // Read data is captured here so it is valid alongside the ack.
          if (r_grant_id) begin
            r_ack1 <= 1'b1;
            if (!r_we) begin
              r_rdata1 <= mem_rdata;
            end
          end else begin
            r_ack0 <= 1'b1;
            if (!r_we) begin
              r_rdata0 <= mem_rdata;
            end
          end
        end
        RESP: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign WR_EN_DM  = r_wr_en;
  assign RD_EN_DM  = r_rd_en;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign busy      = r_busy;
  assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a simple behavioural data memory.
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  logic                  clk;
  logic                  rst;
  logic                  req0, req1, we0, we1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  ack0, ack1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;
  logic                  WR_EN_DM, RD_EN_DM;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy, grant_id;

  int checks;
  int errors;

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  dm_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .WR_EN_DM(WR_EN_DM), .RD_EN_DM(RD_EN_DM),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous write, combinational read of the presented address.
  always @(posedge clk) begin
    if (WR_EN_DM) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({busy, WR_EN_DM, RD_EN_DM, ack0, ack1, grant_id} !== 6'b000000) begin
      errors++;
      $display("FAIL reset_ctrl got busy/wr/rd/ack0/ack1/gid=%b want 000000",
               {busy, WR_EN_DM, RD_EN_DM, ack0, ack1, grant_id});
    end
    checks++;
    if ({mem_addr, mem_wdata, rdata0, rdata1} !== {8'd0, 19'd0, 19'd0, 19'd0}) begin
      errors++;
      $display("FAIL reset_data got addr=%h wdata=%h rd0=%h rd1=%h want all 0",
               mem_addr, mem_wdata, rdata0, rdata1);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'd10; wdata0 = 19'h12345;
    step();
    checks++;
    if ({WR_EN_DM, RD_EN_DM, busy, grant_id, mem_addr, mem_wdata} !==
        {1'b1, 1'b0, 1'b1, 1'b0, 8'd10, 19'h12345}) begin
      errors++;
      $display("FAIL write_access got wr=%b rd=%b busy=%b gid=%b addr=%0d wdata=%h want 1 0 1 0 10 12345",
               WR_EN_DM, RD_EN_DM, busy, grant_id, mem_addr, mem_wdata);
    end
    step();
    checks++;
    if ({ack0, ack1, WR_EN_DM, RD_EN_DM, busy} !== 5'b10001) begin
      errors++;
      $display("FAIL write_resp got ack0/ack1/wr/rd/busy=%b want 10001",
               {ack0, ack1, WR_EN_DM, RD_EN_DM, busy});
    end
    req0 = 1'b0;
    step();
    checks++;
    if ({ack0, busy, RD_EN_DM, WR_EN_DM} !== 4'b0000) begin
      errors++;
      $display("FAIL write_done got ack0/busy/rd/wr=%b want 0000",
               {ack0, busy, RD_EN_DM, WR_EN_DM});
    end
  endtask

  task automatic test_read_back();
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'd10;
    step();
    checks++;
    if ({RD_EN_DM, WR_EN_DM, grant_id, mem_addr} !== {1'b1, 1'b0, 1'b1, 8'd10}) begin
      errors++;
      $display("FAIL read_access got rd=%b wr=%b gid=%b addr=%0d want 1 0 1 10",
               RD_EN_DM, WR_EN_DM, grant_id, mem_addr);
    end
    step();
    checks++;
    if ({ack1, ack0, rdata1, rdata0} !== {1'b1, 1'b0, 19'h12345, 19'h00000}) begin
      errors++;
      $display("FAIL read_resp got ack1=%b ack0=%b rd1=%h rd0=%h want 1 0 12345 00000",
               ack1, ack0, rdata1, rdata0);
    end
    req1 = 1'b0;
    step();
    step();
    checks++;
    if (rdata1 !== 19'h12345) begin
      errors++;
      $display("FAIL read_hold got rd1=%h want 12345", rdata1);
    end
  endtask

  task automatic test_tie();
    int t_ack0;
    int t_ack1;
    t_ack0 = -1;
    t_ack1 = -1;
    test_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'd20; wdata0 = 19'h1A2B3;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'd20;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (ack0 && t_ack0 < 0) begin t_ack0 = k; req0 = 1'b0; end
      if (ack1 && t_ack1 < 0) begin t_ack1 = k; req1 = 1'b0; end
    end
    checks++;
    if (t_ack0 !== 2 || t_ack1 !== 5) begin
      errors++;
      $display("FAIL tie_order got ack0@%0d ack1@%0d want ack0@2 ack1@5", t_ack0, t_ack1);
    end
    checks++;
    if (rdata1 !== 19'h1A2B3) begin
      errors++;
      $display("FAIL tie_rdata got rd1=%h want 1a2b3", rdata1);
    end
  endtask

  task automatic test_back_to_back();
    int n_ack;
    int seq [6];
    int when [6];
    n_ack = 0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'd40; wdata0 = 19'h00111;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'd41; wdata1 = 19'h00222;
    for (int k = 1; k <= 40 && n_ack < 6; k++) begin
      step();
      if (ack0 || ack1) begin
        seq[n_ack]  = ack1 ? 1 : 0;
        when[n_ack] = k;
        n_ack++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    checks++;
    if (n_ack !== 6) begin
      errors++;
      $display("FAIL rr_count got %0d acks want 6", n_ack);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (seq[i] !== (i % 2)) begin
          errors++;
          $display("FAIL rr_seq[%0d] got %0d want %0d", i, seq[i], i % 2);
        end
      end
      for (int i = 1; i < 6; i++) begin
        checks++;
        if (when[i] - when[i-1] !== 3) begin
          errors++;
          $display("FAIL rr_spacing[%0d] got %0d want 3", i, when[i] - when[i-1]);
        end
      end
    end
    step();
    step();
  endtask

  task automatic test_reset_access();
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'd30; wdata0 = 19'h55555;
    step();
    checks++;
    if (WR_EN_DM !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre got wr=%b want 1", WR_EN_DM);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({ack0, ack1, WR_EN_DM, RD_EN_DM, busy} !== 5'b00000) begin
      errors++;
      $display("FAIL rst_mid got ack0/ack1/wr/rd/busy=%b want 00000",
               {ack0, ack1, WR_EN_DM, RD_EN_DM, busy});
    end
    step();
    checks++;
    if ({WR_EN_DM, ack0, grant_id, mem_addr} !== {1'b1, 1'b0, 1'b0, 8'd30}) begin
      errors++;
      $display("FAIL reissue_access got wr=%b ack0=%b gid=%b addr=%0d want 1 0 0 30",
               WR_EN_DM, ack0, grant_id, mem_addr);
    end
    step();
    checks++;
    if ({ack0, WR_EN_DM} !== 2'b10) begin
      errors++;
      $display("FAIL reissue_ack got ack0/wr=%b want 10", {ack0, WR_EN_DM});
    end
    req0 = 1'b0;
    step();
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if ({WR_EN_DM, RD_EN_DM, ack0, ack1, busy} !== 5'b00000 || mem_addr !== 8'd30) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL idle got %0d bad cycles want 0 (last wr/rd/ack0/ack1/busy=%b addr=%0d)",
               bad, {WR_EN_DM, RD_EN_DM, ack0, ack1, busy}, mem_addr);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < (1 << ADDR_WIDTH); i++) mem[i] = '0;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    test_reset();
    test_single_write();
    test_read_back();
    test_tie();
    test_back_to_back();
    test_reset_access();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
